// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam int COIN5_VAL  = 5;
  localparam int COIN10_VAL = 10;
  localparam int COIN25_VAL = 25;

endpackage

// File: rtl/vending_ctrl_coin_decode.sv
// Combinational coin decoder: value of a single coin plus multi/any flags.
module coin_decode
  import vending_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         coin_5,
  input  logic         coin_10,
  input  logic         coin_25,
  output logic [W-1:0] value,
  output logic         multi,
  output logic         any
);

  always_comb begin
    value = '0;
    case ({coin_25, coin_10, coin_5})
      3'b001:  value = W'(COIN5_VAL);
      3'b010:  value = W'(COIN10_VAL);
      3'b100:  value = W'(COIN25_VAL);
      default: value = '0;
    endcase
  end

  assign multi = (coin_5 & coin_10) | (coin_5 & coin_25) | (coin_10 & coin_25);
  assign any   = coin_5 | coin_10 | coin_25;

endmodule

// File: rtl/vending_ctrl.sv
// Credit-accumulating vending FSM: credits coins, dispenses at PRICE,
// returns change or refunds on cancel; every output is registered.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_5,
  input  logic                coin_10,
  input  logic                coin_25,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic [1:0]          state
);

  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic                coin_reject_q, coin_reject_d;

  logic [CREDIT_W-1:0] coin_val;
  logic                coin_multi;
  logic                coin_any;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;

  coin_decode #(.W(CREDIT_W)) u_coin_decode (
    .coin_5  (coin_5),
    .coin_10 (coin_10),
    .coin_25 (coin_25),
    .value   (coin_val),
    .multi   (coin_multi),
    .any     (coin_any)
  );

  // One extra bit so the overflow compare never sees a wrapped sum.
  assign sum = {1'b0, credit_q} + {1'b0, coin_val};

  assign coin_ok = coin_any && !coin_multi && !cancel &&
                   (state_q == IDLE || state_q == COLLECT) && (sum <= MAX_W);

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    change_amt_d  = '0;
    coin_reject_d = coin_any && !coin_ok;
    case (state_q)
      IDLE, COLLECT: begin
        if (coin_ok) begin
          credit_d = sum[CREDIT_W-1:0];
          state_d  = (sum >= PRICE_W) ? VEND : COLLECT;
        end else if (state_q == COLLECT && cancel) begin
          state_d      = CHANGE;
          change_amt_d = credit_q;
        end
      end
      VEND: begin
        if (credit_q > PRICE_C) begin
          state_d      = CHANGE;
          change_amt_d = credit_q - PRICE_C;
        end else begin
          state_d  = IDLE;
          credit_d = '0;
        end
      end
      CHANGE: begin
        state_d  = IDLE;
        credit_d = '0;
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    dispense_d     = (state_d == VEND);
    change_valid_d = (state_d == CHANGE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      change_amt_q   <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_amt_q   <= change_amt_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      coin_reject_q  <= coin_reject_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign state        = state_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench: vector table on a PRICE=15 instance, hand sequences for overflow and reset.
module tb_vending_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_c5 = 0, a_c10 = 0, a_c25 = 0, a_cn = 0;
  logic [6:0] a_credit, a_chg;
  logic a_disp, a_chv, a_rej;
  logic [1:0] a_st;

  logic b_c5 = 0, b_c10 = 0, b_c25 = 0, b_cn = 0;
  logic [6:0] b_credit, b_chg;
  logic b_disp, b_chv, b_rej;
  logic [1:0] b_st;

  vending_ctrl #(.PRICE(15), .MAX_CREDIT(95), .CREDIT_W(7)) dut (
    .clk(clk), .rst(rst), .coin_5(a_c5), .coin_10(a_c10), .coin_25(a_c25), .cancel(a_cn),
    .credit(a_credit), .dispense(a_disp), .change_valid(a_chv), .change_amt(a_chg),
    .coin_reject(a_rej), .state(a_st)
  );

  vending_ctrl #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(7)) dut95 (
    .clk(clk), .rst(rst), .coin_5(b_c5), .coin_10(b_c10), .coin_25(b_c25), .cancel(b_cn),
    .credit(b_credit), .dispense(b_disp), .change_valid(b_chv), .change_amt(b_chg),
    .coin_reject(b_rej), .state(b_st)
  );

  typedef struct {
    logic       c5, c10, c25, cn;
    logic [6:0] cr;
    logic       ck_cr;
    logic       disp, chv;
    logic [6:0] chg;
    logic       rej;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic c5, c10, c25, cn, input int cr, input logic ck_cr,
                              input logic disp, chv, input int chg, input logic rej, input int st);
    vec_t v;
    v.c5 = c5; v.c10 = c10; v.c25 = c25; v.cn = cn;
    v.cr = 7'(cr); v.ck_cr = ck_cr; v.disp = disp; v.chv = chv;
    v.chg = 7'(chg); v.rej = rej; v.st = 2'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step_a(input logic c5, c10, c25, cn);
    @(negedge clk);
    a_c5 = c5; a_c10 = c10; a_c25 = c25; a_cn = cn;
    @(posedge clk);
    #1;
    a_c5 = 0; a_c10 = 0; a_c25 = 0; a_cn = 0;
  endtask

  task automatic step_b(input logic c5, c10, c25);
    @(negedge clk);
    b_c5 = c5; b_c10 = c10; b_c25 = c25; b_cn = 0;
    @(posedge clk);
    #1;
    b_c5 = 0; b_c10 = 0; b_c25 = 0;
  endtask

  task automatic chk_zero_a(input string nm);
    chk({nm, ".state"}, a_st, 0);
    chk({nm, ".credit"}, a_credit, 0);
    chk({nm, ".chg"}, a_chg, 0);
    chk({nm, ".outs"}, {a_disp, a_chv, a_rej}, 0);
  endtask

  initial begin
    //             c5 c10 c25 cn  cr ck  d  cv chg rj st
    vecs.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 20, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 5, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0,  5, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 15, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0, 1, 10, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 25, 1, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0, 1, 10, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 0, 1, 10, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0,  0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));

    #12;
    chk_zero_a("reset15");
    chk("reset95.state", b_st, 0);
    chk("reset95.credit", b_credit, 0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[i]) begin
      step_a(vecs[i].c5, vecs[i].c10, vecs[i].c25, vecs[i].cn);
      total++;
      if (a_st != vecs[i].st || a_disp != vecs[i].disp || a_chv != vecs[i].chv ||
          a_chg != vecs[i].chg || a_rej != vecs[i].rej ||
          (vecs[i].ck_cr && a_credit != vecs[i].cr)) begin
        bad++;
        $display("FAIL vec%0d: got st=%0d cr=%0d disp=%0b chv=%0b chg=%0d rej=%0b expected st=%0d cr=%0d disp=%0b chv=%0b chg=%0d rej=%0b",
                 i, a_st, a_credit, a_disp, a_chv, a_chg, a_rej,
                 vecs[i].st, vecs[i].cr, vecs[i].disp, vecs[i].chv, vecs[i].chg, vecs[i].rej);
      end
    end

    // Overflow boundary at PRICE = MAX_CREDIT = 95.
    step_b(0, 0, 1);
    step_b(0, 0, 1);
    step_b(0, 0, 1);
    step_b(0, 1, 0);
    step_b(1, 0, 0);
    chk("ovf.credit90", b_credit, 90);
    chk("ovf.state90", b_st, 1);
    step_b(0, 1, 0);
    chk("ovf.reject", b_rej, 1);
    chk("ovf.credit_held", b_credit, 90);
    chk("ovf.state_held", b_st, 1);
    chk("ovf.no_disp", b_disp, 0);
    step_b(1, 0, 0);
    chk("ovf.disp", b_disp, 1);
    chk("ovf.credit95", b_credit, 95);
    chk("ovf.rej_clear", b_rej, 0);
    step_b(0, 0, 0);
    chk("ovf.idle", b_st, 0);
    chk("ovf.idle_credit", b_credit, 0);
    chk("ovf.no_change", b_chv, 0);

    // Asynchronous reset while in CHANGE.
    step_a(0, 1, 0, 0);
    step_a(0, 0, 0, 1);
    chk("rstchg.chv_before", a_chv, 1);
    #2 rst = 1;
    #1;
    chk_zero_a("rstchg");
    @(negedge clk);
    rst = 0;
    step_a(1, 0, 0, 0);
    chk("rstchg.after_credit", a_credit, 5);
    chk("rstchg.after_state", a_st, 1);

    // Asynchronous reset while in VEND.
    step_a(0, 1, 0, 0);
    chk("rstvend.disp_before", a_disp, 1);
    #2 rst = 1;
    #1;
    chk_zero_a("rstvend");
    @(negedge clk);
    rst = 0;
    step_a(0, 0, 1, 0);
    chk("rstvend.after_credit", a_credit, 25);
    chk("rstvend.after_disp", a_disp, 1);
    step_a(0, 0, 0, 0);
    chk("rstvend.after_chg", a_chg, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
